tape_prefetch: RTL and testbench
================================

// Module: tape_prefetch
// PURPOSE
//  Prefetches tape-image bytes from SDRAM into a small FIFO that feeds the tape player.
//  Sits between the sram controller and the tape module.
//  Issues one SDRAM read per Z80 refresh cycle (nRFSH low), so tape fetches never steal CPU memory slots.
//  The tape module pops bytes through a valid/ack handshake instead of waiting on ad-hoc refresh timing.
// PARAMETERS
//  DEPTH      8   FIFO entries; power of 2, >=2
//  ADDR_W     25  SDRAM byte address width
//  ACK_DELAY  7   clk cycles mem_rd is held before mem_din is captured (>=2)
// PORTS
//  clk        in   1       clk_sys, 28 MHz
//  nRESET     in   1       asynchronous reset, active low
//  nRFSH      in   1       Z80 refresh strobe, clk_cpu domain, active low
//  enable     in   1       1 = fetching allowed (tape loaded, not downloading)
//  flush      in   1       1-cycle pulse: empty FIFO, fetch address := 0
//  size       in   ADDR_W  tape image length in bytes
//  mem_rd     out  1       SDRAM read request (muxed onto sram rd during refresh)
//  mem_addr   out  ADDR_W  SDRAM read address
//  mem_din    in   8       SDRAM read data (sram dout)
//  dout       out  8       FIFO head byte
//  dvalid     out  1       FIFO non-empty; dout is valid
//  dack       in   1       consumer pop; ignored when dvalid=0
//  eof        out  1       all bytes fetched and FIFO empty
// BEHAVIOUR
//  Reset
//  - nRESET low clears the FIFO and fetch_addr, forces the FSM to IDLE, and drives all outputs to 0.
//  - Release of nRESET is synchronised inside the block.
//  Refresh detect
//  - nRFSH passes through a 2-flop synchroniser.
//  - rfsh_fall = synced previous 1, current 0.
//  - rfsh_rise = synced previous 0, current 1.
//  Fetch FSM
//  - IDLE -> READ on rfsh_fall when all hold: enable=1, fetch_addr<size, level+inflight<DEPTH.
//    A FIFO slot is reserved at this point.
//  - READ: mem_rd=1 and mem_addr=fetch_addr; cnt counts ACK_DELAY..1.
//    - At cnt==1: capture mem_din, push it into the FIFO, fetch_addr+=1, mem_rd:=0, go to IDLE.
//    - rfsh_rise before cnt==1: abort. mem_rd:=0, no push, fetch_addr unchanged, go to IDLE. The same byte is retried on the next refresh.
//  - mem_addr holds its last value in IDLE; mem_rd=0 in every state except READ.
//  - At most one read per refresh cycle. A new rfsh_fall is needed after each completion or abort.
//  FIFO
//  - Circular buffer; rd/wr pointers wrap at DEPTH; level is log2(DEPTH)+1 bits.
//  - dout is registered and equals the head entry.
//    - Push into an empty FIFO: dvalid rises the cycle after the push.
//    - Pop with another entry queued: the next byte appears the cycle after dack.
//  - Push and pop in the same cycle: both happen, level unchanged.
//  - A push can never overflow, because the slot was reserved at READ entry.
//  - dack while dvalid=0: no effect.
//  Flush / enable
//  - flush has priority over every other event.
//    - FIFO emptied, fetch_addr:=0, an in-flight READ is aborted (mem_rd:=0 next cycle), FSM to IDLE, dvalid:=0.
//  - enable falling mid-READ: the read completes normally. No new read starts while enable=0.
//  - size < fetch_addr (image shrunk): no further fetches; eof=1 once the FIFO is empty.
//  eof = (fetch_addr>=size) && !dvalid && FSM==IDLE.
// TESTING
//  1. Reset, size=3, enable=1, three refresh pulses (8 clk low each), mem_din=A0/A1/A2.
//     Required: mem_addr 0,1,2 issued; dout A0,A1,A2 in order with dack; eof=1 after the last pop.
//  2. No dack, 10 refresh pulses, DEPTH=8.
//     Required: exactly 8 mem_rd bursts; level=8; the 9th and 10th refreshes produce no mem_rd.
//  3. nRFSH low for only 3 clk (abort).
//     Required: mem_rd drops on rfsh_rise; no push. The next 8-clk refresh re-reads the same address and pushes once.
//  4. flush asserted during cnt=4 of a READ with 2 bytes buffered.
//     Required: mem_rd=0 next cycle; dvalid=0; the next fetch uses addr 0.
//  5. Level=8 (full); dack and read-completion in the same cycle.
//     Required: level stays 8; bytes stay ordered; no overflow flagged.
//  6. nRESET asserted mid-READ.
//     Required: mem_rd, dvalid, eof, mem_addr, dout are 0 immediately (async); after release, fetching restarts at addr 0.

Source files
------------

// File: rtl/tape_prefetch.sv
// tape_prefetch: fetches tape-image bytes from SDRAM during Z80 refresh slots
// into a small FIFO that the tape player pops through a valid/ack handshake.
module tape_prefetch #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ADDR_W    = 25,
    parameter int unsigned ACK_DELAY = 7
) (
    input  logic              clk,
    input  logic              nRESET,
    input  logic              nRFSH,
    input  logic              enable,
    input  logic              flush,
    input  logic [ADDR_W-1:0] size,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_din,
    output logic [7:0]        dout,
    output logic              dvalid,
    input  logic              dack,
    output logic              eof
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(ACK_DELAY + 1);

    typedef enum logic {IDLE, READ} state_t;

    state_t             state, state_next;
    logic [1:0]         rst_sync;
    logic               rst_n;
    logic               rfsh_meta, rfsh_sync, rfsh_prev;
    logic               rfsh_fall, rfsh_rise;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  fetch_addr;
    logic               start, push, pop;
    logic [7:0]         buffer [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr, rd_ptr_next;
    logic [LVL_W-1:0]   level, level_next;

    // Assertion is immediate; release waits two clocks.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) rst_sync <= '0;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rfsh_meta <= 1'b1;
            rfsh_sync <= 1'b1;
            rfsh_prev <= 1'b1;
        end else begin
            rfsh_meta <= nRFSH;
            rfsh_sync <= rfsh_meta;
            rfsh_prev <= rfsh_sync;
        end
    end
    assign rfsh_fall =  rfsh_prev & ~rfsh_sync;
    assign rfsh_rise = ~rfsh_prev &  rfsh_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // No read is ever in flight while IDLE, so level alone decides slot availability.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (!flush && rfsh_fall && enable && (fetch_addr < size) &&
                    (level < LVL_W'(DEPTH))) begin
                    start      = 1'b1;
                    state_next = READ;
                end
            end
            READ: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (cnt == CNT_W'(1)) begin
                    push       = 1'b1;
                    state_next = IDLE;
                end else if (rfsh_rise) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            fetch_addr <= '0;
            mem_addr   <= '0;
        end else if (flush) begin
            cnt        <= '0;
            fetch_addr <= '0;
        end else if (start) begin
            cnt        <= CNT_W'(ACK_DELAY);
            mem_addr   <= fetch_addr;
        end else if (state == READ) begin
            cnt <= cnt - CNT_W'(1);
            if (push) fetch_addr <= fetch_addr + ADDR_W'(1);
        end
    end

    assign mem_rd = (state == READ);
    assign pop    = dack & dvalid;

    always_ff @(posedge clk) begin
        if (push) buffer[wr_ptr] <= mem_din;
    end

    always_comb begin
        level_next  = level;
        rd_ptr_next = rd_ptr;
        if (flush) begin
            level_next  = '0;
            rd_ptr_next = '0;
        end else begin
            if (pop) rd_ptr_next = rd_ptr + PTR_W'(1);
            if (push && !pop)      level_next = level + LVL_W'(1);
            else if (pop && !push) level_next = level - LVL_W'(1);
        end
    end

    // When the next head is the byte being pushed it is not in buffer yet,
    // so it is forwarded straight from mem_din.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            dvalid <= 1'b0;
            dout   <= '0;
        end else begin
            rd_ptr <= rd_ptr_next;
            level  <= level_next;
            dvalid <= (level_next != '0);
            if (flush)     wr_ptr <= '0;
            else if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (level_next == '0)
                dout <= '0;
            else if (push && level_next == LVL_W'(1))
                dout <= mem_din;
            else
                dout <= buffer[rd_ptr_next];
        end
    end

    assign eof = rst_n && (fetch_addr >= size) && !dvalid && (state == IDLE);

endmodule

// File: tb/tb_tape_prefetch.sv
// Self-checking bench for tape_prefetch: directed vector table, hand-written
// corner sequences, then random refresh/pop traffic against a queue model.
module tb_tape_prefetch;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        nRESET, nRFSH, enable, flush, dack;
    logic [24:0] size;
    logic        mem_rd, dvalid, eof;
    logic [24:0] mem_addr;
    logic [7:0]  mem_din, dout;

    tape_prefetch #(.DEPTH(8), .ADDR_W(25), .ACK_DELAY(7)) dut (
        .clk(clk), .nRESET(nRESET), .nRFSH(nRFSH), .enable(enable), .flush(flush),
        .size(size), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_din(mem_din),
        .dout(dout), .dvalid(dvalid), .dack(dack), .eof(eof)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] data_of(input int a);
        return 8'hA0 + a[7:0];
    endfunction

    assign mem_din = data_of(int'(mem_addr));

    int total = 0;
    int bad   = 0;

    // Log of every read burst: count and the address presented at its start.
    int          bursts = 0;
    logic [24:0] baddr[$];
    logic        rd_prev = 1'b0;
    always @(negedge clk) begin
        if (mem_rd && !rd_prev) begin
            bursts++;
            baddr.push_back(mem_addr);
        end
        rd_prev = mem_rd;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        bursts = 0;
        baddr.delete();
    endtask

    task automatic pulse(input int len);
        nRFSH = 1'b0;
        tick(len);
        nRFSH = 1'b1;
        tick(6);
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        check({name, " dvalid"}, {31'd0, dvalid}, 32'd1);
        check({name, " dout"}, {24'd0, dout}, {24'd0, exp});
        dack = 1'b1;
        tick(1);
        dack = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(1);
    endtask

    typedef struct {
        int len;
        bit en;
        int npops;
        bit exp_burst;
        int exp_addr;
        bit exp_dvalid;
        bit exp_eof;
    } vec_t;

    // Queue model for the random phase.
    logic [7:0] mq[$];
    int maddr, msize;
    bit men;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int   pop_idx;
        tbl[0] = '{8, 1'b1, 0, 1'b1, 0, 1'b1, 1'b0};
        tbl[1] = '{3, 1'b1, 0, 1'b1, 1, 1'b1, 1'b0};
        tbl[2] = '{8, 1'b1, 1, 1'b1, 1, 1'b1, 1'b0};
        tbl[3] = '{8, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0};
        tbl[4] = '{8, 1'b1, 0, 1'b1, 2, 1'b1, 1'b0};
        tbl[5] = '{8, 1'b1, 0, 1'b1, 3, 1'b1, 1'b0};
        tbl[6] = '{8, 1'b1, 0, 1'b0, 0, 1'b1, 1'b0};
        tbl[7] = '{0, 1'b1, 3, 1'b0, 0, 1'b0, 1'b1};

        nRESET = 1'b0; nRFSH = 1'b1; enable = 1'b0; flush = 1'b0; dack = 1'b0; size = '0;
        tick(2);
        check("reset mem_rd",   {31'd0, mem_rd}, 32'd0);
        check("reset mem_addr", {7'd0, mem_addr}, 32'd0);
        check("reset dout",     {24'd0, dout}, 32'd0);
        check("reset dvalid",   {31'd0, dvalid}, 32'd0);
        check("reset eof",      {31'd0, eof}, 32'd0);
        nRESET = 1'b1;
        tick(4);

        // Directed table: size=4, includes an aborted refresh and an enable=0 slot.
        size = 25'd4;
        pop_idx = 0;
        for (int i = 0; i < 8; i++) begin
            enable = tbl[i].en;
            clear_log();
            if (tbl[i].len > 0) pulse(tbl[i].len);
            check($sformatf("vec%0d bursts", i), bursts, tbl[i].exp_burst ? 1 : 0);
            if (tbl[i].exp_burst && baddr.size() > 0)
                check($sformatf("vec%0d addr", i), {7'd0, baddr[0]}, tbl[i].exp_addr);
            for (int p = 0; p < tbl[i].npops; p++) begin
                pop_check($sformatf("vec%0d pop%0d", i, p), data_of(pop_idx));
                pop_idx++;
            end
            check($sformatf("vec%0d dvalid", i), {31'd0, dvalid}, {31'd0, tbl[i].exp_dvalid});
            check($sformatf("vec%0d eof", i), {31'd0, eof}, {31'd0, tbl[i].exp_eof});
        end

        // Fill to DEPTH with no consumer: 10 refreshes, only 8 reads.
        enable = 1'b1;
        size = 25'd20;
        do_flush();
        clear_log();
        for (int i = 0; i < 10; i++) pulse(8);
        check("full bursts", bursts, DEPTH);
        for (int i = 0; i < DEPTH && i < baddr.size(); i++)
            check($sformatf("full addr%0d", i), {7'd0, baddr[i]}, i);

        // Pop one, then pop in the very cycle the next read completes.
        pop_check("full pop0", data_of(0));
        clear_log();
        nRFSH = 1'b0;
        tick(8);
        nRFSH = 1'b1;
        tick(1);
        check("same-cycle mem_rd before", {31'd0, mem_rd}, 32'd1);
        pop_check("same-cycle pop", data_of(1));
        check("same-cycle mem_rd after", {31'd0, mem_rd}, 32'd0);
        tick(5);
        check("same-cycle bursts", bursts, 1);
        for (int i = 2; i <= 8; i++) pop_check($sformatf("drain%0d", i), data_of(i));
        check("drain dvalid", {31'd0, dvalid}, 32'd0);

        // Flush during a read with two bytes buffered.
        do_flush();
        pulse(8);
        pulse(8);
        nRFSH = 1'b0;
        tick(6);
        check("flush mem_rd before", {31'd0, mem_rd}, 32'd1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("flush mem_rd", {31'd0, mem_rd}, 32'd0);
        check("flush dvalid", {31'd0, dvalid}, 32'd0);
        tick(1);
        nRFSH = 1'b1;
        tick(6);
        clear_log();
        pulse(8);
        check("post-flush bursts", bursts, 1);
        if (baddr.size() > 0) check("post-flush addr", {7'd0, baddr[0]}, 32'd0);
        pop_check("post-flush pop", data_of(0));

        // Asynchronous reset in the middle of a read.
        do_flush();
        pulse(8);
        pulse(8);
        nRFSH = 1'b0;
        tick(5);
        check("rst mem_rd before", {31'd0, mem_rd}, 32'd1);
        check("rst mem_addr before", {7'd0, mem_addr}, 32'd2);
        nRESET = 1'b0;
        #1;
        check("rst mem_rd",   {31'd0, mem_rd}, 32'd0);
        check("rst dvalid",   {31'd0, dvalid}, 32'd0);
        check("rst eof",      {31'd0, eof}, 32'd0);
        check("rst mem_addr", {7'd0, mem_addr}, 32'd0);
        check("rst dout",     {24'd0, dout}, 32'd0);
        nRFSH = 1'b1;
        tick(3);
        nRESET = 1'b1;
        tick(4);
        clear_log();
        pulse(8);
        check("post-rst bursts", bursts, 1);
        if (baddr.size() > 0) check("post-rst addr", {7'd0, baddr[0]}, 32'd0);
        pop_check("post-rst pop", data_of(0));
        check("post-rst dvalid", {31'd0, dvalid}, 32'd0);

        // Random traffic against the queue model.
        do_flush();
        mq.delete();
        maddr = 0;
        msize = $urandom_range(5, 30);
        size  = 25'(msize);
        for (int it = 0; it < 60; it++) begin
            int  len, npops;
            bit  exp_burst;
            int  lens[4];
            lens = '{3, 5, 8, 12};
            men    = ($urandom_range(0, 3) != 0);
            enable = men;
            if ($urandom_range(0, 15) == 0) begin
                msize = $urandom_range(0, maddr + 2);
                size  = 25'(msize);
            end
            len = lens[$urandom_range(0, 3)];
            clear_log();
            pulse(len);
            exp_burst = men && (maddr < msize) && (mq.size() < DEPTH);
            check($sformatf("rnd%0d bursts", it), bursts, exp_burst ? 1 : 0);
            if (exp_burst && baddr.size() > 0)
                check($sformatf("rnd%0d addr", it), {7'd0, baddr[0]}, maddr);
            if (exp_burst && len >= 7) begin
                mq.push_back(data_of(maddr));
                maddr++;
            end
            npops = $urandom_range(0, 3);
            for (int p = 0; p < npops && mq.size() > 0; p++)
                pop_check($sformatf("rnd%0d pop%0d", it, p), mq.pop_front());
            check($sformatf("rnd%0d dvalid", it), {31'd0, dvalid}, (mq.size() != 0) ? 1 : 0);
            check($sformatf("rnd%0d eof", it), {31'd0, eof},
                  ((maddr >= msize) && (mq.size() == 0)) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
